pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline register for the IF/ID boundary, and reusable at any stage boundary that carries an instruction word, PC and sideband.
- Adds three things to the plain stall/flush register: a valid/ready upstream handshake, an optional one-entry skid buffer so a late downstream stall never drops a fetched word, and a stage kill that overrides stall.
- Keeps the existing semantics: flushed words become NOP but keep PC; branch-delay-slot words do not update restart PC; an is-flushed flag masks interrupt capture downstream.

Parameters:
- INST_W, 32, instruction width.
- PC_W, 32, PC width.
- SIDE_W, 8, opaque sideband bits carried alongside the instruction.
- NOP_VALUE, 0, instruction value driven for a bubble or flushed word (INST_W bits).
- SKID_EN, 1, 1 = one-entry skid buffer present; 0 = no skid, combinational ready.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  synchronous active-low reset.
- up_valid  in  1  upstream word present.
- up_ready  out  1  stage accepts the upstream word this cycle.
- up_inst  in  INST_W  instruction.
- up_pc  in  PC_W  PC of the instruction.
- up_pc_add4  in  PC_W  PC+4.
- up_is_bds  in  1  word is a branch delay slot.
- up_flush  in  1  turn the incoming word into NOP.
- up_side  in  SIDE_W  sideband.
- dn_stall  in  1  downstream stall; output register holds.
- kill  in  1  discard the output register and skid contents this cycle.
- dn_valid  out  1  output word valid.
- dn_inst  out  INST_W  registered instruction.
- dn_pc_add4  out  PC_W  registered PC+4.
- dn_restart_pc  out  PC_W  restart PC for exceptions.
- dn_is_bds  out  1  registered BDS flag.
- dn_is_flushed  out  1  output word was flushed or killed.
- dn_side  out  SIDE_W  registered sideband.
- skid_full  out  1  skid entry occupied (constant 0 when SKID_EN=0).

Behaviour:
- Reset (RST_N=0 at a CLK edge) forces: dn_valid=0, dn_inst=NOP_VALUE, dn_pc_add4=0, dn_restart_pc=0, dn_is_bds=0, dn_is_flushed=0, dn_side=0, skid_full=0.
- Reset mid-operation discards the skid contents.
- Priority at each edge: reset > kill > dn_stall > load.
- up_ready:
  - SKID_EN=1: up_ready = !skid_full, which depends only on registered state.
  - SKID_EN=0: up_ready = !dn_stall && !kill, combinational.
- Accept: an upstream word is accepted when up_valid && up_ready at a CLK edge. Latency from accept to the dn_* outputs is 1 cycle when the stage is not stalled.
- Load source when !dn_stall && !kill: the skid entry if skid_full, otherwise the upstream word.
  - When the load comes from the skid, skid_full clears at that edge.
  - The upstream word is not accepted that cycle, because up_ready=0.
- Skid capture (SKID_EN=1): dn_stall && !kill && accept stores the upstream word in the skid and sets skid_full. The output register holds.
- Loaded word with flush=1 (up_flush at accept time, stored in the skid with the word): dn_inst=NOP_VALUE, dn_is_flushed=1, dn_valid=1. dn_pc_add4, dn_is_bds and dn_side are captured normally.
- Loaded word with flush=0: all fields captured; dn_is_flushed=0.
- No word available (no accept and skid empty, not stalled): insert a bubble.
  - dn_valid=0, dn_inst=NOP_VALUE, dn_is_flushed=0, dn_is_bds=0.
  - dn_pc_add4 and dn_side hold; dn_restart_pc holds.
- dn_restart_pc:
  - Updates to the loaded word's PC only when that word's is_bds=0.
  - A BDS word keeps the previous restart PC, which is the branch's PC.
  - Applies identically to skid-sourced words.
- kill (regardless of dn_stall):
  - Output register: dn_valid=0, dn_inst=NOP_VALUE, dn_is_flushed=1, dn_is_bds=0.
  - skid_full clears.
  - dn_pc_add4, dn_restart_pc and dn_side hold.
  - No upstream word is accepted when SKID_EN=0.
  - When SKID_EN=1 and up_ready=1, a word presented with up_valid during kill is accepted and then dropped. Upstream must flush its own stage on the same cycle.
- dn_stall with no accept: every output register holds, including dn_is_flushed.
- Stall held for many cycles with the skid full: up_ready stays 0 and no data is lost or duplicated.
- All outputs are registered; no combinational path from any input to any dn_* output.

Decomposition:
- Package pipe_pkg:
  - typedef stage_word_t {inst, pc, pc_add4, is_bds, flush, side}, parametrised via the package's default widths.
  - Constant NOP_INST = 32'h0000_0000.
- One sub-module, pipe_skid_entry: single-entry holding register exposing a full flag, load and pop; instantiated only when SKID_EN=1.

Test Plan:
- Reset: drive RST_N=0 with up_valid=1 for 2 cycles -> dn_valid=0, dn_inst=0, dn_restart_pc=0, skid_full=0; first word after release appears 1 cycle after accept.
- Skid: accept inst 0x24420001 (pc 0x100) while dn_stall=1 -> skid_full=1, up_ready=0, dn_* unchanged. Release stall -> dn_inst=0x24420001, dn_restart_pc=0x100, skid_full=0, up_ready=1 next cycle.
- BDS: branch at pc 0x200 followed by a BDS word at pc 0x204 -> dn_restart_pc stays 0x200 while the BDS word is in dn_*, and dn_is_bds=1.
- Flush: up_flush=1 with up_inst=0x8C430004 at pc 0x300 -> dn_inst=0, dn_is_flushed=1, dn_valid=1, dn_pc_add4=0x304.
- Kill during stall with skid_full=1 -> next cycle dn_valid=0, dn_is_flushed=1, skid_full=0, dn_pc_add4 unchanged.
- SKID_EN=0, dn_stall=1 -> up_ready=0 in the same cycle; 10-cycle stall loses and duplicates nothing (scoreboard compare).

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared default widths, NOP encoding and the stage word type
package pipe_pkg;
  localparam int DEF_INST_W = 32;
  localparam int DEF_PC_W = 32;
  localparam int DEF_SIDE_W = 8;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  typedef struct packed {
    logic [DEF_INST_W-1:0] inst;
    logic [DEF_PC_W-1:0] pc;
    logic [DEF_PC_W-1:0] pc_add4;
    logic is_bds;
    logic flush;
    logic [DEF_SIDE_W-1:0] side;
  } stage_word_t;
endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: single-entry holding register with full flag, load and pop
module pipe_skid_entry import pipe_pkg::*; #(
  parameter int W = $bits(stage_word_t)
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic         pop,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);
  always_ff @(posedge CLK)
    if (!RST_N) full <= 1'b0;
    else if (pop) full <= 1'b0;
    else if (load) full <= 1'b1;
  always_ff @(posedge CLK)
    if (load) q <= d;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: stall/flush/kill pipeline register with valid/ready upstream and optional skid
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int INST_W = 32,
  parameter int PC_W = 32,
  parameter int SIDE_W = 8,
  parameter logic [INST_W-1:0] NOP_VALUE = INST_W'(NOP_INST),
  parameter bit SKID_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [INST_W-1:0] up_inst,
  input  logic [PC_W-1:0]   up_pc,
  input  logic [PC_W-1:0]   up_pc_add4,
  input  logic              up_is_bds,
  input  logic              up_flush,
  input  logic [SIDE_W-1:0] up_side,
  input  logic              dn_stall,
  input  logic              kill,
  output logic              dn_valid,
  output logic [INST_W-1:0] dn_inst,
  output logic [PC_W-1:0]   dn_pc_add4,
  output logic [PC_W-1:0]   dn_restart_pc,
  output logic              dn_is_bds,
  output logic              dn_is_flushed,
  output logic [SIDE_W-1:0] dn_side,
  output logic              skid_full
);
  localparam int W = INST_W + 2 * PC_W + 2 + SIDE_W;
  logic [W-1:0] up_word, skid_q;
  logic [INST_W-1:0] s_inst;
  logic [PC_W-1:0] s_pc, s_pc_add4;
  logic s_bds, s_flush, accept, load;
  logic [SIDE_W-1:0] s_side;
  assign up_word = {up_inst, up_pc, up_pc_add4, up_is_bds, up_flush, up_side};
  assign up_ready = SKID_EN ? !skid_full : !dn_stall && !kill;
  assign accept = up_valid && up_ready;
  // a parked skid word always drains before any new upstream word
  assign {s_inst, s_pc, s_pc_add4, s_bds, s_flush, s_side} = skid_full ? skid_q : up_word;
  assign load = !dn_stall && !kill && (skid_full || accept);
  if (SKID_EN) begin : g_skid
    pipe_skid_entry #(.W(W)) u_skid (
      .CLK(CLK),
      .RST_N(RST_N),
      .load(dn_stall && !kill && accept),
      .pop(kill || load),
      .d(up_word),
      .q(skid_q),
      .full(skid_full)
    );
  end else begin : g_no_skid
    assign skid_full = 1'b0;
    assign skid_q = '0;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dn_valid <= 1'b0;
      dn_inst <= NOP_VALUE;
      dn_pc_add4 <= '0;
      dn_restart_pc <= '0;
      dn_is_bds <= 1'b0;
      dn_is_flushed <= 1'b0;
      dn_side <= '0;
    end else if (kill) begin
      dn_valid <= 1'b0;
      dn_inst <= NOP_VALUE;
      dn_is_flushed <= 1'b1;
      dn_is_bds <= 1'b0;
    end else if (!dn_stall) begin
      dn_valid <= load;
      dn_inst <= (load && !s_flush) ? s_inst : NOP_VALUE;
      dn_is_flushed <= load && s_flush;
      dn_is_bds <= load && s_bds;
      if (load) begin
        dn_pc_add4 <= s_pc_add4;
        dn_side <= s_side;
        if (!s_bds) dn_restart_pc <= s_pc;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of skid and no-skid stage registers against a behavioural model
module tb_pipe_stage_reg;
  import pipe_pkg::*;
  typedef struct packed {
    logic valid;
    logic [31:0] inst, pa4, rpc;
    logic bds, fl;
    logic [7:0] side;
    logic sk;
    stage_word_t sw;
  } mst_t;
  logic CLK = 1'b0, RST_N = 1'b0, chk_en = 1'b0;
  always #5 CLK = ~CLK;
  stage_word_t a_w, b_w;
  logic a_valid, a_stall, a_kill, b_valid, b_stall, b_kill;
  logic a_ready, a_dv, a_bds, a_fl, a_skid, b_ready, b_dv, b_bds, b_fl, b_skid;
  logic [31:0] a_inst, a_pa4, a_rpc, b_inst, b_pa4, b_rpc;
  logic [7:0] a_side, b_side;
  int vecs = 0, errs = 0;
  mst_t ma, mb;
  logic [31:0] got[$];
  pipe_stage_reg #(.SKID_EN(1'b1)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .up_valid(a_valid), .up_ready(a_ready),
    .up_inst(a_w.inst), .up_pc(a_w.pc), .up_pc_add4(a_w.pc_add4), .up_is_bds(a_w.is_bds),
    .up_flush(a_w.flush), .up_side(a_w.side), .dn_stall(a_stall), .kill(a_kill),
    .dn_valid(a_dv), .dn_inst(a_inst), .dn_pc_add4(a_pa4), .dn_restart_pc(a_rpc),
    .dn_is_bds(a_bds), .dn_is_flushed(a_fl), .dn_side(a_side), .skid_full(a_skid)
  );
  pipe_stage_reg #(.SKID_EN(1'b0)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .up_valid(b_valid), .up_ready(b_ready),
    .up_inst(b_w.inst), .up_pc(b_w.pc), .up_pc_add4(b_w.pc_add4), .up_is_bds(b_w.is_bds),
    .up_flush(b_w.flush), .up_side(b_w.side), .dn_stall(b_stall), .kill(b_kill),
    .dn_valid(b_dv), .dn_inst(b_inst), .dn_pc_add4(b_pa4), .dn_restart_pc(b_rpc),
    .dn_is_bds(b_bds), .dn_is_flushed(b_fl), .dn_side(b_side), .skid_full(b_skid)
  );
  // next model state from the stage's documented rules, one clock edge at a time
  function automatic mst_t step(mst_t s, logic rn, logic v, stage_word_t w, logic st, logic k, bit sk_en);
    mst_t n;
    logic acc;
    stage_word_t src;
    n = s;
    acc = v && (sk_en ? !s.sk : (!st && !k));
    if (!rn) return mst_t'(0);
    if (k) begin
      n.valid = 1'b0; n.inst = 32'h0; n.fl = 1'b1; n.bds = 1'b0; n.sk = 1'b0;
      return n;
    end
    if (st) begin
      if (acc) begin n.sk = 1'b1; n.sw = w; end
      return n;
    end
    if (s.sk || acc) begin
      src = s.sk ? s.sw : w;
      n.sk = 1'b0; n.valid = 1'b1;
      n.inst = src.flush ? 32'h0 : src.inst;
      n.pa4 = src.pc_add4; n.bds = src.is_bds; n.fl = src.flush; n.side = src.side;
      if (!src.is_bds) n.rpc = src.pc;
    end else begin
      n.valid = 1'b0; n.inst = 32'h0; n.fl = 1'b0; n.bds = 1'b0;
    end
    return n;
  endfunction
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic aw(input logic v, input logic [31:0] i, input logic [31:0] p, input logic bds, input logic fl, input logic [7:0] s);
    a_valid = v;
    a_w.inst = i; a_w.pc = p; a_w.pc_add4 = p + 32'd4; a_w.is_bds = bds; a_w.flush = fl; a_w.side = s;
  endtask
  always @(posedge CLK) begin
    ma <= step(ma, RST_N, a_valid, a_w, a_stall, a_kill, 1'b1);
    mb <= step(mb, RST_N, b_valid, b_w, b_stall, b_kill, 1'b0);
    if (chk_en && RST_N && b_dv && !b_stall && !b_kill) got.push_back(b_inst);
  end
  always @(negedge CLK) if (chk_en) begin
    cmp("a_ready", a_ready, !ma.sk);
    cmp("a_valid", a_dv, ma.valid);
    cmp("a_inst", a_inst, ma.inst);
    cmp("a_pc_add4", a_pa4, ma.pa4);
    cmp("a_restart_pc", a_rpc, ma.rpc);
    cmp("a_is_bds", a_bds, ma.bds);
    cmp("a_is_flushed", a_fl, ma.fl);
    cmp("a_side", a_side, ma.side);
    cmp("a_skid_full", a_skid, ma.sk);
    cmp("b_ready", b_ready, !b_stall && !b_kill);
    cmp("b_valid", b_dv, mb.valid);
    cmp("b_inst", b_inst, mb.inst);
    cmp("b_pc_add4", b_pa4, mb.pa4);
    cmp("b_restart_pc", b_rpc, mb.rpc);
    cmp("b_is_flushed", b_fl, mb.fl);
    cmp("b_skid_full", b_skid, 1'b0);
  end
  initial begin
    int n;
    logic acc;
    a_stall = 0; a_kill = 0; b_valid = 0; b_stall = 0; b_kill = 0; b_w = '0;
    aw(1, 32'h1, 32'h10, 0, 0, 8'h00);
    tick();
    chk_en = 1'b1;
    tick();
    cmp("rst_valid", a_dv, 0);
    cmp("rst_inst", a_inst, 0);
    cmp("rst_restart_pc", a_rpc, 0);
    cmp("rst_skid", a_skid, 0);
    RST_N = 1'b1;
    aw(1, 32'h11, 32'h40, 0, 0, 8'h5a);
    tick();
    cmp("first_valid", a_dv, 1);
    cmp("first_inst", a_inst, 32'h11);
    aw(0, 32'h0, 32'h0, 0, 0, 8'h00);
    tick();
    cmp("bubble_valid", a_dv, 0);
    cmp("bubble_side_hold", a_side, 8'h5a);
    a_stall = 1;
    aw(1, 32'h2442_0001, 32'h100, 0, 0, 8'h01);
    tick();
    cmp("skid_full", a_skid, 1);
    cmp("skid_ready", a_ready, 0);
    cmp("skid_dn_hold", a_dv, 0);
    aw(1, 32'h2442_0002, 32'h104, 0, 0, 8'h02);
    tick();
    tick();
    cmp("skid_long_stall", a_skid, 1);
    a_stall = 0;
    tick();
    cmp("skid_drain_inst", a_inst, 32'h2442_0001);
    cmp("skid_drain_rpc", a_rpc, 32'h100);
    cmp("skid_drain_empty", a_skid, 0);
    cmp("skid_drain_ready", a_ready, 1);
    tick();
    cmp("after_skid_inst", a_inst, 32'h2442_0002);
    aw(1, 32'h1000_0003, 32'h200, 0, 0, 8'h03);
    tick();
    aw(1, 32'h2463_0001, 32'h204, 1, 0, 8'h04);
    tick();
    cmp("bds_rpc", a_rpc, 32'h200);
    cmp("bds_flag", a_bds, 1);
    aw(1, 32'h8C43_0004, 32'h300, 0, 1, 8'h05);
    tick();
    cmp("flush_inst", a_inst, 0);
    cmp("flush_flag", a_fl, 1);
    cmp("flush_valid", a_dv, 1);
    cmp("flush_pc_add4", a_pa4, 32'h304);
    aw(1, 32'hAAAA_0001, 32'h400, 0, 0, 8'h06);
    tick();
    a_stall = 1;
    aw(1, 32'hAAAA_0002, 32'h500, 0, 0, 8'h07);
    tick();
    cmp("kill_pre_skid", a_skid, 1);
    a_kill = 1;
    aw(0, 32'h0, 32'h0, 0, 0, 8'h00);
    tick();
    cmp("kill_valid", a_dv, 0);
    cmp("kill_flushed", a_fl, 1);
    cmp("kill_skid", a_skid, 0);
    cmp("kill_pc_add4", a_pa4, 32'h404);
    a_kill = 0;
    tick();
    a_stall = 0;
    tick();
    aw(1, 32'hDEAD_0001, 32'h600, 0, 0, 8'h08);
    a_kill = 1;
    tick();
    a_kill = 0;
    aw(0, 32'h0, 32'h0, 0, 0, 8'h00);
    tick();
    cmp("kill_drop_valid", a_dv, 0);
    aw(1, 32'hBBBB_0001, 32'h700, 0, 0, 8'h09);
    a_stall = 1;
    tick();
    RST_N = 1'b0;
    tick();
    cmp("midrst_skid", a_skid, 0);
    RST_N = 1'b1;
    a_stall = 0;
    aw(0, 32'h0, 32'h0, 0, 0, 8'h00);
    tick();
    cmp("midrst_discard", a_dv, 0);
    for (int c = 0; c < 40; c++) begin
      a_stall = ($urandom % 10) < 3;
      a_kill = ($urandom % 12) == 0;
      aw(($urandom % 4) != 0, $urandom, 32'h800 + 32'(c * 4), ($urandom % 5) == 0, ($urandom % 6) == 0, 8'($urandom));
      tick();
    end
    a_stall = 0; a_kill = 0;
    aw(0, 32'h0, 32'h0, 0, 0, 8'h00);
    tick();
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      b_stall = (c >= 3 && c < 13);
      b_valid = 1;
      b_w.inst = 32'hB000_0000 + 32'(n); b_w.pc = 32'(n * 4); b_w.pc_add4 = 32'(n * 4 + 4);
      #1;
      if (c == 3) cmp("b_stall_ready_now", b_ready, 0);
      acc = b_ready;
      @(posedge CLK);
      #1;
      if (acc) n++;
    end
    b_valid = 0; b_stall = 0;
    tick();
    tick();
    tick();
    cmp("b_sent_all", 32'(n), 6);
    cmp("b_got_count", 32'(got.size()), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) cmp("b_order", got[i], 32'hB000_0000 + 32'(i));
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
